div4: RTL and testbench
=======================

# div4

Synchronous clock divider that produces `dev4_clk` at one quarter of the input clock frequency with 50 % duty cycle. It is a general even-ratio divider whose default ratio is 4. All state is clocked on the rising edge of `clk`. Output is a registered, glitch-free signal for use as a slow clock or clock-enable reference.

## Interface
- `DIV_RATIO`, default 4: integer division ratio; must be even and ≥ 2; any other value is an elaboration-time error.
- `CNT_W`, default `$clog2(DIV_RATIO/2)` (minimum 1): half-period counter width, derived, not user-set.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `dev4_clk`  output  1  divided clock, driven directly from a flip-flop.

## Operation
- Internal half-period counter `cnt` (`CNT_W` bits), range 0 … `DIV_RATIO/2 − 1`.
- Reset (`reset`=1 at a rising edge): `cnt` ← 0, `dev4_clk` ← 0. Reset has priority over counting.
- Each rising edge with `reset`=0:
  - If `cnt` = `DIV_RATIO/2 − 1`: `dev4_clk` ← ~`dev4_clk`, `cnt` ← 0.
  - Otherwise: `cnt` ← `cnt` + 1, `dev4_clk` holds.
- For `DIV_RATIO`=2, `cnt` is always at terminal value, so the output toggles every edge (divide by 2).
- Counter never wraps past its terminal value; unreachable counter values (non-power-of-two half ratios) must return to 0 on the next edge.
- `dev4_clk` is undefined until the first rising edge with `reset`=1. No asynchronous path exists.
- No combinational path from any input to `dev4_clk`.

## Timing
- Output period = `DIV_RATIO` input periods; high time = low time = `DIV_RATIO/2` input periods.
- Default ratio 4: after reset deassertion, the first edge with `reset`=0 advances `cnt` 0→1. The second edge sets `dev4_clk` to 1. The output then toggles every 2 input edges.
- Example with a 25 ns `clk` period (rising edges at 12.5, 37.5, 62.5, … ns) and `reset` falling at 30 ns:
  - `dev4_clk` = 0 from 12.5 ns.
  - Rises at 62.5 ns, falls at 112.5 ns, rises at 162.5 ns, …
  - Period 100 ns.
- Reset asserted mid-operation: at the next rising edge `dev4_clk` = 0 and `cnt` = 0 regardless of phase. Restart timing is identical to power-up.
- Reset held for multiple cycles: output stays 0 and the counter stays 0.
- All output transitions coincide with `clk` rising edges (one flop clk-to-q delay).

## Test plan
- Power-up, default ratio: 25 ns clock, `reset`=1 until 30 ns. Required: `dev4_clk`=0 at 12.5 ns, 1 at 62.5 ns, 0 at 112.5 ns; steady 100 ns period, 50 % duty through 1000 ns.
- Mid-run reset: run 10 output periods, assert `reset` for 1 cycle while `dev4_clk`=1. Required: `dev4_clk`=0 at that edge; it rises again exactly 2 edges after `reset` deasserts.
- Reset held for 5 cycles. Required: `dev4_clk` constant 0 and no toggles during reset.
- Duty/period check: count `clk` rising edges between consecutive `dev4_clk` rising edges over 50 periods. Required: always 4; high phase exactly 2 edges.
- `DIV_RATIO`=2 and `DIV_RATIO`=10. Required: periods of 2 and 10 input cycles; first rise at edge 1 and edge 5 after reset release respectively; 50 % duty.
- `DIV_RATIO`=3 or 0. Required: elaboration fails with an error.

Source files
------------

// File: rtl/div4.sv
// Even-ratio clock divider: dev4_clk = clk / DIV_RATIO at 50% duty, registered output.
// Free-running with no handshake; a synchronous reset restarts the phase from low.
module div4 #(
    parameter int DIV_RATIO = 4
) (
    input  logic clk,
    input  logic reset,
    output logic dev4_clk
);

    localparam int HALF  = DIV_RATIO / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF - 1);

    if (DIV_RATIO < 2 || (DIV_RATIO % 2) != 0) begin : g_bad_ratio
        $error("div4: DIV_RATIO must be even and >= 2");
    end

    logic [CNT_W-1:0] cnt;

    // Values above TERM only exist when HALF is not a power of two; they fall back to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            dev4_clk <= 1'b0;
        end else if (cnt == TERM) begin
            cnt      <= '0;
            dev4_clk <= ~dev4_clk;
        end else if (cnt > TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_div4.sv
// Bench for div4 at ratios 2, 4 and 10: directed timing pins plus a reset-phase model under random resets.
`timescale 1ns/1ps
module tb_div4;

    bit   clk;
    logic reset;
    logic d2, d4, d10;

    int errors = 0;
    int checks = 0;

    // Model state: edges seen since the last reset edge, per instance.
    int ratio [3] = '{2, 4, 10};
    int k     [3] = '{0, 0, 0};
    bit known [3] = '{0, 0, 0};

    div4 #(.DIV_RATIO(2))  u_div2  (.clk(clk), .reset(reset), .dev4_clk(d2));
    div4 #(.DIV_RATIO(4))  u_div4  (.clk(clk), .reset(reset), .dev4_clk(d4));
    div4 #(.DIV_RATIO(10)) u_div10 (.clk(clk), .reset(reset), .dev4_clk(d10));

    always #12.5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // After k non-reset edges the output has completed k/(R/2) half periods, starting low.
    function automatic logic model_out(input int r, input int kk);
        return ((kk / (r / 2)) % 2) == 1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                k[i]     = 0;
                known[i] = 1'b1;
            end else if (known[i]) begin
                k[i]++;
            end
        end
    end

    always @(negedge clk) begin
        if (known[0]) chk("model_ratio2",  d2,  model_out(ratio[0], k[0]));
        if (known[1]) chk("model_ratio4",  d4,  model_out(ratio[1], k[1]));
        if (known[2]) chk("model_ratio10", d10, model_out(ratio[2], k[2]));
    end

    initial begin
        int   since, hl, rises;
        logic prev;
        bit   found;

        reset = 1'b1;
        #13.5;
        chk("pwrup_r4_low",  d4,  1'b0);
        chk("pwrup_r2_low",  d2,  1'b0);
        chk("pwrup_r10_low", d10, 1'b0);
        #16.5 reset = 1'b0;
        #8.5;
        chk("r2_first_rise", d2, 1'b1);
        #25;
        chk("r4_rise_62p5", d4, 1'b1);
        chk("r2_low_62p5",  d2, 1'b0);
        #50;
        chk("r4_fall_112p5", d4,  1'b0);
        chk("r10_low_112p5", d10, 1'b0);
        #25;
        chk("r10_first_rise", d10, 1'b1);

        // Period and duty of the ratio-4 output over 50 full periods.
        since = 0; hl = 0; rises = 0;
        prev  = d4;
        for (int n = 0; n < 260 && rises < 51; n++) begin
            @(negedge clk);
            since++;
            if (!prev && d4) begin
                if (rises > 0) chk_int("period_edges", since, 4);
                rises++;
                since = 0;
                hl    = 0;
            end
            if (prev && !d4) chk_int("high_edges", hl, 2);
            if (d4) hl++;
            prev = d4;
        end
        chk_int("period_rises_seen", rises, 51);

        // One-cycle reset while the output is high.
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            @(negedge clk);
            if (d4) found = 1'b1;
        end
        chk("midrun_found_high", found, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrun_reset_low", d4, 1'b0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("midrun_edge1_low", d4, 1'b0);
        @(posedge clk); #1;
        chk("midrun_edge2_high", d4, 1'b1);

        // Reset held for five edges.
        @(negedge clk) reset = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_r4",  d4,  1'b0);
            chk("hold_r2",  d2,  1'b0);
            chk("hold_r10", d10, 1'b0);
        end
        @(negedge clk) reset = 1'b0;

        // Random reset pulses at arbitrary phases, checked by the model.
        repeat (2000) begin
            @(negedge clk);
            reset = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk) reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
